// File: rtl/bpf16_out_quant.sv
// rtl/bpf16_out_quant.sv - FIR accumulator round/shift/saturate stage with 2-entry output FIFO
module bpf16_out_quant #(
   parameter int ACC_WIDTH     = 32,
   parameter int OUTPUT_WIDTH  = 16,
   parameter int SHIFT_RIGHT   = 11,
   parameter int SAT_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ACC_WIDTH-1:0]     in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUTPUT_WIDTH-1:0]  out_data,
   input  logic                     clr_stats,
   output logic                     sat_flag,
   output logic [SAT_CNT_WIDTH-1:0] sat_count
);

   localparam logic signed [ACC_WIDTH:0] ROUND_V =
      {{(ACC_WIDTH+1-SHIFT_RIGHT){1'b0}}, 1'b1, {(SHIFT_RIGHT-1){1'b0}}};
   localparam logic signed [ACC_WIDTH:0] MAX_V =
      {{(ACC_WIDTH+2-OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] MIN_V =
      {{(ACC_WIDTH+2-OUTPUT_WIDTH){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};
   localparam logic [OUTPUT_WIDTH-1:0]   OUT_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
   localparam logic [OUTPUT_WIDTH-1:0]   OUT_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
   localparam logic [SAT_CNT_WIDTH-1:0]  CNT_ONE = {{(SAT_CNT_WIDTH-1){1'b0}}, 1'b1};

   logic signed [ACC_WIDTH:0]  sum_ext;
   logic signed [ACC_WIDTH:0]  rounded;
   logic                       sat_hi;
   logic                       sat_lo;
   logic [OUTPUT_WIDTH-1:0]    quant;
   logic                       push;
   logic                       pop;

   logic [OUTPUT_WIDTH-1:0]    mem_q [0:1];
   logic                       wr_ptr_q, wr_ptr_d;
   logic                       rd_ptr_q, rd_ptr_d;
   logic [1:0]                 count_q, count_d;
   logic                       sat_flag_q, sat_flag_d;
   logic [SAT_CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;

   // One extra bit of headroom so the rounding offset can never overflow.
   always_comb begin
      sum_ext = $signed({in_data[ACC_WIDTH-1], in_data}) + ROUND_V;
      rounded = sum_ext >>> SHIFT_RIGHT;
      sat_hi  = (rounded > MAX_V);
      sat_lo  = (rounded < MIN_V);
      if (sat_hi)
         quant = OUT_MAX;
      else if (sat_lo)
         quant = OUT_MIN;
      else
         quant = rounded[OUTPUT_WIDTH-1:0];
   end

   assign in_ready  = (count_q < 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign sat_flag  = sat_flag_q;
   assign sat_count = sat_cnt_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ pop;
      count_d    = count_q;
      sat_flag_d = sat_flag_q;
      sat_cnt_d  = sat_cnt_q;
      if (push && !pop)
         count_d = count_q + 2'd1;
      else if (!push && pop)
         count_d = count_q - 2'd1;
      // Clear wins over a saturation event in the same cycle.
      if (clr_stats) begin
         sat_flag_d = 1'b0;
         sat_cnt_d  = '0;
      end else if (push && (sat_hi || sat_lo)) begin
         sat_flag_d = 1'b1;
         if (!(&sat_cnt_q))
            sat_cnt_d = sat_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         sat_flag_q <= 1'b0;
         sat_cnt_q  <= '0;
      end else begin
         if (push)
            mem_q[wr_ptr_q] <= quant;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         sat_flag_q <= sat_flag_d;
         sat_cnt_q  <= sat_cnt_d;
      end
   end

endmodule

// File: tb/tb_bpf16_out_quant.sv
// tb/tb_bpf16_out_quant.sv - directed self-checking bench for bpf16_out_quant
module tb_bpf16_out_quant;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        clr_stats;
   logic        sat_flag;
   logic [15:0] sat_count;

   int total;
   int bad;
   int q[$];

   bpf16_out_quant dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .clr_stats (clr_stats),
      .sat_flag  (sat_flag),
      .sat_count (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int din [4];
   int dexp[4];

   initial begin
      int k;
      bit acc;
      bit pp;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 32'd0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      #12;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_data", int'($signed(out_data)), 0);
      chk("rst_sat_flag", int'(sat_flag), 0);
      chk("rst_sat_count", int'(sat_count), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // rounding vectors
      din  = '{1024, 1023, -1024, -1025};
      dexp = '{1, 0, 0, -1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = din[i];
         step();
         chk($sformatf("round_valid%0d", i), int'(out_valid), 1);
         chk($sformatf("round_data%0d", i), int'($signed(out_data)), dexp[i]);
      end
      in_valid = 1'b0;
      step();
      chk("round_drained", int'(out_valid), 0);
      chk("round_satcnt", int'(sat_count), 0);

      // saturation boundaries
      in_valid = 1'b1;
      in_data  = 32'd67106816;
      step();
      chk("sat_edge_data", int'($signed(out_data)), 32767);
      chk("sat_edge_flag", int'(sat_flag), 0);
      in_data  = 32'd67107840;
      step();
      chk("sat_hi_data", int'($signed(out_data)), 32767);
      chk("sat_hi_flag", int'(sat_flag), 1);
      chk("sat_hi_cnt", int'(sat_count), 1);
      in_data  = 32'h8000_0000;
      step();
      chk("sat_lo_data", int'($signed(out_data)), -32768);
      chk("sat_lo_cnt", int'(sat_count), 2);
      in_valid = 1'b0;
      step();

      // backpressure: 3 offered, 2 stored
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'd10240;
      step();
      chk("bp_ready1", int'(in_ready), 1);
      chk("bp_data1", int'($signed(out_data)), 5);
      in_data = 32'd12288;
      step();
      chk("bp_ready2", int'(in_ready), 0);
      chk("bp_data2", int'($signed(out_data)), 5);
      in_data = 32'd14336;
      step();
      chk("bp_ready3", int'(in_ready), 0);
      chk("bp_hold", int'($signed(out_data)), 5);
      out_ready = 1'b1;
      step();
      chk("bp_drain1", int'($signed(out_data)), 6);
      chk("bp_ready4", int'(in_ready), 1);
      step();
      chk("bp_drain2", int'($signed(out_data)), 7);
      chk("bp_valid2", int'(out_valid), 1);
      in_valid = 1'b0;
      step();
      chk("bp_empty", int'(out_valid), 0);

      // random push/pop against a queue model, starting at count=1
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'(100 * 2048);
      step();
      q.push_back(100);
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("rnd_ready%0d", i), int'(in_ready), (q.size() < 2) ? 1 : 0);
         chk($sformatf("rnd_valid%0d", i), int'(out_valid), (q.size() > 0) ? 1 : 0);
         if (q.size() > 0)
            chk($sformatf("rnd_data%0d", i), int'($signed(out_data)), q[0]);
         k = int'($urandom_range(200)) - 100;
         in_data   = 32'(k * 2048);
         in_valid  = (i == 0) ? 1'b1 : 1'($urandom_range(1));
         out_ready = (i == 0) ? 1'b1 : 1'($urandom_range(1));
         acc = in_valid && (q.size() < 2);
         pp  = out_ready && (q.size() > 0);
         step();
         if (pp)
            void'(q.pop_front());
         if (acc)
            q.push_back(k);
         if (i == 0)
            chk("rnd_pushpop_count1", int'(out_valid) + int'(!in_ready), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      q.delete();
      chk("rnd_empty", int'(out_valid), 0);

      // saturation counter ceiling, then clear against a simultaneous event
      in_valid = 1'b1;
      in_data  = 32'h8000_0000;
      for (int i = 0; i < 65540; i++)
         step();
      chk("cnt_ceiling", int'(sat_count), 65535);
      chk("cnt_flag", int'(sat_flag), 1);
      clr_stats = 1'b1;
      step();
      chk("clr_cnt", int'(sat_count), 0);
      chk("clr_flag", int'(sat_flag), 0);
      chk("clr_data", int'($signed(out_data)), -32768);
      chk("clr_valid", int'(out_valid), 1);
      clr_stats = 1'b0;
      in_valid  = 1'b0;
      step();

      // reset with 2 samples buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'd20480;
      step();
      step();
      in_valid = 1'b0;
      chk("mid_full", int'(in_ready), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_ready", int'(in_ready), 1);
      chk("mid_rst_data", int'($signed(out_data)), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_stale", int'(out_valid), 0);
      in_valid = 1'b1;
      in_data  = 32'd4096;
      step();
      chk("post_rst_valid", int'(out_valid), 1);
      chk("post_rst_data", int'($signed(out_data)), 2);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("post_rst_drain", int'(out_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
